// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter that shares one external binary-to-BCD converter
// among N_REQ requesters. A grant registers the clamped operand into
// conv_bin, the converter settles for one cycle (CONV), and the BCD result
// is captured with the source id on the DONE edge, where ack/valid pulse.
module bcd_conv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int BIN_W   = 10,
  parameter int BCD_W   = 12,
  parameter int MAX_VAL = 999,
  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*BIN_W-1:0] bin_in,
  output logic [N_REQ-1:0]       ack,
  output logic [BIN_W-1:0]       conv_bin,
  input  logic [BCD_W-1:0]       conv_bcd,
  output logic [BCD_W-1:0]       bcd_out,
  output logic [IDW-1:0]         src_id,
  output logic                   ovf,
  output logic                   valid,
  output logic                   busy
);

  localparam logic [BIN_W-1:0] MAX_V = BIN_W'(MAX_VAL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     gid_q, gid_d;
  logic               clamp_q, clamp_d;
  logic [BIN_W-1:0]   conv_bin_q, conv_bin_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic [IDW-1:0]     src_id_q, src_id_d;
  logic               ovf_q, ovf_d;

  logic [N_REQ-1:0]   req_mask;
  logic               win_found;
  logic [IDW-1:0]     win_id;
  logic [IDW:0]       scan_sum;
  logic [IDW-1:0]     scan_idx;
  logic [BIN_W-1:0]   win_opnd;
  logic               win_clamp;
  logic               grant;

  // Round-robin search from ptr with wraparound; the requester just served
  // is masked in DONE because it only drops req after seeing its ack.
  always_comb begin
    req_mask  = req;
    win_found = 1'b0;
    win_id    = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    if (state_q == S_DONE) req_mask[gid_q] = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(N_REQ)) scan_sum = scan_sum - (IDW+1)'(N_REQ);
      scan_idx = scan_sum[IDW-1:0];
      if (!win_found && req_mask[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  // Operand mux for the winner plus unsigned clamp to MAX_VAL.
  always_comb begin
    win_opnd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_id == IDW'(i)) win_opnd = bin_in[i*BIN_W +: BIN_W];
    end
    win_clamp = (win_opnd > MAX_V);
  end

  // Next-state logic: IDLE waits for any req, CONV always moves to DONE,
  // DONE chains straight into the next grant when another req is pending.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant   = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: state_d = S_DONE;
      S_DONE: begin
        if (win_found) begin
          grant   = 1'b1;
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: operand/pointer load on grant, result capture on
  // the CONV->DONE edge; everything else holds.
  always_comb begin
    ptr_d      = ptr_q;
    gid_d      = gid_q;
    clamp_d    = clamp_q;
    conv_bin_d = conv_bin_q;
    bcd_out_d  = bcd_out_q;
    src_id_d   = src_id_q;
    ovf_d      = ovf_q;
    if (grant) begin
      gid_d      = win_id;
      ptr_d      = (win_id == IDW'(N_REQ-1)) ? '0 : win_id + IDW'(1);
      clamp_d    = win_clamp;
      conv_bin_d = win_clamp ? MAX_V : win_opnd;
    end
    if (state_q == S_CONV) begin
      bcd_out_d = conv_bcd;
      src_id_d  = gid_q;
      ovf_d     = clamp_q;
    end
  end

  // State and datapath registers; reset discards any in-flight conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      gid_q      <= '0;
      clamp_q    <= 1'b0;
      conv_bin_q <= '0;
      bcd_out_q  <= '0;
      src_id_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gid_q      <= gid_d;
      clamp_q    <= clamp_d;
      conv_bin_q <= conv_bin_d;
      bcd_out_q  <= bcd_out_d;
      src_id_q   <= src_id_d;
      ovf_q      <= ovf_d;
    end
  end

  // ack/valid are decoded from DONE so they pulse exactly one cycle.
  always_comb begin
    ack = '0;
    if (state_q == S_DONE) ack[gid_q] = 1'b1;
  end

  assign valid    = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);
  assign conv_bin = conv_bin_q;
  assign bcd_out  = bcd_out_q;
  assign src_id   = src_id_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: directed vector table, contention/fairness and
// async-reset sequences, then randomized rounds against a transaction model.
module tb_bcd_conv_arbiter;

  localparam int N = 4;
  localparam int W = 10;
  localparam int B = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] bin_in;
  logic [N-1:0]   ack;
  logic [W-1:0]   conv_bin;
  logic [B-1:0]   conv_bcd;
  logic [B-1:0]   bcd_out;
  logic [1:0]     src_id;
  logic           ovf;
  logic           valid;
  logic           busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  bcd_conv_arbiter #(.N_REQ(N), .BIN_W(W), .BCD_W(B), .MAX_VAL(999)) dut (
    .clk(clk), .rst(rst), .req(req), .bin_in(bin_in), .ack(ack),
    .conv_bin(conv_bin), .conv_bcd(conv_bcd), .bcd_out(bcd_out),
    .src_id(src_id), .ovf(ovf), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int clampv(int v);
    return (v > 999) ? 999 : v;
  endfunction

  // external combinational converter
  assign conv_bcd = to_bcd(int'(conv_bin));

  task automatic chk(string nm, int act, int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  task automatic set_bin(int id, int val);
    bin_in[id*W +: W] = W'(val);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // wait for valid at successive negedges; n = cycles waited
  task automatic wait_valid(string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 10);
    if (!valid) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic one(int id, int val, int ecbin, logic [11:0] ebcd, logic eovf, string nm);
    int n;
    @(negedge clk);
    set_bin(id, val);
    req[id] = 1'b1;
    @(negedge clk);
    chk({nm, "_conv_bin"}, int'(conv_bin), ecbin);
    chk({nm, "_busy_conv"}, int'(busy), 1);
    chk({nm, "_novalid_conv"}, int'(valid), 0);
    n = 1;
    if (!valid) begin
      int m;
      wait_valid(nm, m);
      n += m;
    end
    chk({nm, "_latency"}, n, 2);
    chk({nm, "_ack"}, int'(ack), 1 << id);
    chk({nm, "_bcd"}, int'(bcd_out), int'(ebcd));
    chk({nm, "_src"}, int'(src_id), id);
    chk({nm, "_ovf"}, int'(ovf), int'(eovf));
    req[id] = 1'b0;
    @(negedge clk);
    chk({nm, "_ack_drop"}, int'(ack), 0);
    chk({nm, "_idle"}, int'(busy), 0);
    chk({nm, "_hold"}, int'(bcd_out), int'(ebcd));
  endtask

  typedef struct {
    int          id;
    int          val;
    int          cbin;
    logic [11:0] bcd;
    logic        ovf;
    string       nm;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n, k, cnt, expid, mptr, budget;
    logic [N-1:0] pending;
    int vals[N];
    logic [11:0] cexp[4];

    tbl[0] = '{0, 123,  123,  12'h123, 1'b0, "v123"};
    tbl[1] = '{0, 0,    0,    12'h000, 1'b0, "v0"};
    tbl[2] = '{0, 9,    9,    12'h009, 1'b0, "v9"};
    tbl[3] = '{0, 10,   10,   12'h010, 1'b0, "v10"};
    tbl[4] = '{0, 59,   59,   12'h059, 1'b0, "v59"};
    tbl[5] = '{0, 999,  999,  12'h999, 1'b0, "v999"};
    tbl[6] = '{0, 1001, 999,  12'h999, 1'b1, "v1001"};
    tbl[7] = '{0, 1023, 999,  12'h999, 1'b1, "v1023"};
    tbl[8] = '{3, 1000, 999,  12'h999, 1'b1, "v1000_r3"};
    tbl[9] = '{2, 480,  480,  12'h480, 1'b0, "v480_r2"};

    rst = 1'b1;
    req = '0;
    bin_in = '0;
    #12;
    chk("rst_conv_bin", int'(conv_bin), 0);
    chk("rst_bcd", int'(bcd_out), 0);
    chk("rst_src", int'(src_id), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // directed vector table
    for (int i = 0; i < 10; i++)
      one(tbl[i].id, tbl[i].val, tbl[i].cbin, tbl[i].bcd, tbl[i].ovf, tbl[i].nm);

    // contention: all four requesters at once
    do_reset();
    cexp[0] = 12'h001; cexp[1] = 12'h010; cexp[2] = 12'h100; cexp[3] = 12'h999;
    @(negedge clk);
    set_bin(0, 1); set_bin(1, 10); set_bin(2, 100); set_bin(3, 999);
    req = 4'b1111;
    k = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("cont_busy_c%0d", c), int'(busy), 1);
      chk($sformatf("cont_valid_c%0d", c), int'(valid), (c % 2 == 0) ? 1 : 0);
      if (valid && k < 4) begin
        chk($sformatf("cont_ack_c%0d", c), int'(ack), 1 << k);
        chk($sformatf("cont_src_c%0d", c), int'(src_id), k);
        chk($sformatf("cont_bcd_c%0d", c), int'(bcd_out), int'(cexp[k]));
        req[k] = 1'b0;
        k++;
      end
    end
    @(negedge clk);
    chk("cont_idle", int'(busy), 0);

    // fairness: req0 and req2 held
    do_reset();
    @(negedge clk);
    bin_in = '0;
    set_bin(0, 7); set_bin(2, 300);
    req = 4'b0101;
    expid = 0;
    cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (valid) begin
        chk($sformatf("fair_src_%0d", cnt), int'(src_id), expid);
        chk($sformatf("fair_bcd_%0d", cnt), int'(bcd_out), (expid == 0) ? 12'h007 : 12'h300);
        expid = (expid == 0) ? 2 : 0;
        cnt++;
      end
    end
    chk("fair_count", cnt, 6);
    req = '0;
    @(negedge clk);
    @(negedge clk);

    // async reset mid-CONV
    one(1, 321, 321, 12'h321, 1'b0, "pre_rst");
    @(negedge clk);
    set_bin(0, 123);
    req = 4'b0001;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_conv_bin", int'(conv_bin), 0);
    chk("arst_bcd", int'(bcd_out), 0);
    chk("arst_valid", int'(valid), 0);
    chk("arst_ack", int'(ack), 0);
    chk("arst_busy", int'(busy), 0);
    req = '0;
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (valid || ack != 0) cnt++;
    end
    chk("arst_no_ack", cnt, 0);
    rst = 1'b0;
    set_bin(0, 5); set_bin(2, 250);
    req = 4'b0101;
    wait_valid("arst_ptr0", n);
    chk("arst_ptr0_lat", n, 2);
    chk("arst_ptr0_src", int'(src_id), 0);
    chk("arst_ptr0_bcd", int'(bcd_out), 12'h005);
    req[0] = 1'b0;
    wait_valid("arst_ptr2", n);
    chk("arst_ptr2_src", int'(src_id), 2);
    req[2] = 1'b0;
    @(negedge clk);
    do_reset();
    one(2, 250, 250, 12'h250, 1'b0, "arst_req2");

    // randomized rounds against a round-robin transaction model
    do_reset();
    mptr = 0;
    for (int r = 0; r < 25; r++) begin
      @(negedge clk);
      pending = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        vals[i] = $urandom_range(0, 1023);
        if ($urandom_range(0, 3) == 0) vals[i] = 997 + $urandom_range(0, 5);
        set_bin(i, vals[i]);
      end
      req = pending;
      budget = 0;
      while (pending != 0 && budget < 40) begin
        @(negedge clk);
        budget++;
        if (valid) begin
          expid = -1;
          for (int j = 0; j < N; j++)
            if (expid < 0 && pending[(mptr + j) % N]) expid = (mptr + j) % N;
          chk($sformatf("rnd%0d_src", r), int'(src_id), expid);
          chk($sformatf("rnd%0d_ack", r), int'(ack), 1 << expid);
          chk($sformatf("rnd%0d_bcd", r), int'(bcd_out), int'(to_bcd(clampv(vals[expid]))));
          chk($sformatf("rnd%0d_ovf", r), int'(ovf), (vals[expid] > 999) ? 1 : 0);
          pending[expid] = 1'b0;
          req[expid] = 1'b0;
          mptr = (expid + 1) % N;
        end
      end
      chk($sformatf("rnd%0d_drained", r), int'(pending), 0);
      req = '0;
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares a single combinational binary-to-BCD converter (10-bit binary in, 12-bit packed 3-digit BCD out) among N_REQ requesters, for example score, timer and counter display sources.
- Round-robin arbitration and a req/ack handshake decide which requester uses the converter.
- The chosen value is registered into the converter and the BCD result is captured with the source id.
- Inputs above MAX_VAL are clamped to MAX_VAL and flagged, so the converter is only ever driven with 0..999.

Parameters:
N_REQ, 4, number of requesters (2..8)
BIN_W, 10, binary operand width per requester
BCD_W, 12, converter BCD result width (3 digits)
MAX_VAL, 999, largest value passed to the converter; larger inputs are clamped

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req  in  N_REQ  per-requester request; held high until the matching ack
bin_in  in  N_REQ*BIN_W  flattened operands; requester i uses bits [i*BIN_W +: BIN_W], held stable while req[i]=1
ack  out  N_REQ  one-cycle pulse to the served requester, coincident with valid
conv_bin  out  BIN_W  registered operand driven to the external converter
conv_bcd  in  BCD_W  converter result, combinational function of conv_bin
bcd_out  out  BCD_W  captured BCD result
src_id  out  $clog2(N_REQ)  requester index of bcd_out
ovf  out  1  result came from a clamped input
valid  out  1  one-cycle pulse: bcd_out/src_id/ovf updated this cycle
busy  out  1  high in CONV and DONE

Behaviour:
- Reset (async, rst=1):
  - State returns to IDLE and the round-robin pointer ptr goes to 0.
  - conv_bin, bcd_out, src_id, ovf, ack and valid all go to 0; busy=0.
- FSM states:
  - IDLE: busy=0. If any req bit is high, pick the winner and go to CONV. Otherwise stay.
  - CONV: conv_bin holds the clamped operand and the converter settles. Unconditionally go to DONE at the next edge.
  - DONE: on entry edge, capture bcd_out<=conv_bcd, src_id<=gid and ovf<=clamp flag. During this cycle valid=1 and ack[gid]=1.
  - Leaving DONE: if any req other than gid is high, grant the next winner and go directly to CONV. Otherwise go to IDLE.
  - req[gid] is masked during DONE because the requester drops it only after seeing ack.
- Arbitration (round-robin):
  - Search from ptr upward with wraparound; the first asserted req wins (gid).
  - On each grant, ptr <= (gid+1) mod N_REQ.
- Operand path:
  - On the grant edge, conv_bin <= (bin_in[gid] > MAX_VAL) ? MAX_VAL : bin_in[gid].
  - The clamp flag is registered on the same edge.
  - Comparison is unsigned at BIN_W width; a value equal to MAX_VAL is not an overflow.
- Latency:
  - req sampled high in IDLE at edge k gives CONV in cycle k+1 and DONE (valid/ack) in cycle k+2.
  - Under continuous contention the converter completes one conversion every 2 cycles.
- Hold rules:
  - bcd_out, src_id and ovf hold their values between valid pulses.
  - conv_bin holds its last operand in IDLE.
- Requester rules:
  - Deasserting req before ack abandons the request. If the grant was already taken, the conversion still completes and ack pulses anyway.
  - Requester must ignore an ack it did not wait for.
  - req still high one cycle after ack counts as a new request, served in round-robin order.
- Reset during CONV/DONE: the conversion is discarded with no ack, and requesters must re-request.

Test Plan:
- Reset, then req=0001 with bin_in[0]=123:
  - conv_bin=123 in cycle 1.
  - Cycle 2 gives valid=1, ack=0001, bcd_out=12'h123, src_id=0, ovf=0.
  - After ack drops, the FSM returns to IDLE.
- Boundary operands on requester 0: 0 gives h000; 9 gives h009; 10 gives h010; 59 gives h059; 999 gives h999 with ovf=0.
- Clamp on requester 0: bin 1001 and 1023 each give conv_bin=999, bcd_out=h999, ovf=1.
- Contention:
  - Set req=1111 with operands 1/10/100/999, each requester dropping its req after its ack.
  - Required response: acks in order 0,1,2,3 on cycles 2,4,6,8.
  - Each src_id/bcd_out pair must match its operand.
  - busy stays continuously high through cycle 8.
- Fairness:
  - Hold req[0] and req[2] permanently high.
  - Grants must alternate 0,2,0,2; neither requester may be served twice in a row.
- Async reset:
  - Assert rst mid-CONV, asynchronous to clk.
  - Outputs go to 0 immediately, with no ack or valid.
  - After release, ptr=0 and a pending req=0100 is served with src_id=2.
